// File: rtl/axil_mem_read.sv
// axil_mem_read: AXI4-Lite read-only slave front end for a fixed-latency
// synchronous memory.
//
// Read addresses are accepted on a credit basis: at most 2^LGDEPTH reads
// can be outstanding, so the response FIFO always has room for the result
// of every accepted read.
// Each accepted read carries a {valid, err} tag down an RD_LATENCY-deep
// pipeline that runs in step with the memory. When the tag leaves the
// pipeline, the memory word (or zero for an out-of-range word) is written
// into a first-word-fall-through FIFO that feeds the R channel.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN    clock, async active-low reset
//   S_AXI_AR{VALID,READY,ADDR}   read address channel (ARPROT ignored)
//   S_AXI_R{VALID,READY,DATA}    read data channel
//   S_AXI_RRESP                  OKAY (00) or DECERR (11)
//   o_rd_en, o_rd_addr           memory read strobe and word index
//   i_rd_data                    memory data, RD_LATENCY cycles after o_rd_en
module axil_mem_read #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 6,
  parameter int LGDEPTH          = 2,
  parameter int RD_LATENCY       = 1,
  parameter int MEM_WORDS        = 16,
  localparam int LSB             = $clog2(C_AXI_DATA_WIDTH) - 3
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            o_rd_en,
  output logic [C_AXI_ADDR_WIDTH-LSB-1:0] o_rd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]     i_rd_data
);

  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int IW = C_AXI_ADDR_WIDTH - LSB;
  localparam logic [LGDEPTH:0] ONE = (LGDEPTH + 1)'(1);

  logic [LGDEPTH:0]      outst_q, outst_d;
  logic [RD_LATENCY-1:0] pv_q;
  logic [RD_LATENCY-1:0] pe_q;
  logic [LGDEPTH:0]      wptr_q, rptr_q;
  logic [DW+1:0]         fifo_q [1<<LGDEPTH];

  logic          ar_hs, r_hs;
  logic [IW-1:0] word_idx;
  logic [31:0]   idx_ext;
  logic          idx_err;
  logic          push;
  logic [DW+1:0] push_word;
  logic [DW+1:0] head_word;
  logic          fifo_empty;
  logic          unused;

  assign unused = ^{S_AXI_ARPROT, S_AXI_ARADDR[LSB-1:0]};

  assign word_idx = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:LSB];
  assign idx_ext  = 32'(word_idx);
  assign idx_err  = (idx_ext >= 32'(MEM_WORDS));

  // outst_q never exceeds 2^LGDEPTH, so its MSB alone marks "no credit left".
  // Reset gating keeps ARREADY low while reset is held.
  assign S_AXI_ARREADY = S_AXI_ARESETN & ~outst_q[LGDEPTH];

  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

  assign o_rd_en   = ar_hs & ~idx_err;
  assign o_rd_addr = word_idx;

  always_comb begin
    outst_d = outst_q;
    if (ar_hs && !r_hs) begin
      outst_d = outst_q + ONE;
    end else if (!ar_hs && r_hs) begin
      outst_d = outst_q - ONE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      outst_q <= '0;
      pv_q    <= '0;
    end else begin
      outst_q <= outst_d;
      pv_q[0] <= ar_hs;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
      end
    end
  end

  // Error flags only matter where the matching valid bit is set.
  always_ff @(posedge S_AXI_ACLK) begin
    pe_q[0] <= idx_err;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pe_q[k] <= pe_q[k-1];
    end
  end

  assign push      = pv_q[RD_LATENCY-1];
  assign push_word = pe_q[RD_LATENCY-1] ? {{DW{1'b0}}, 2'b11}
                                        : {i_rd_data, 2'b00};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ONE;
      if (r_hs) rptr_q <= rptr_q + ONE;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) fifo_q[wptr_q[LGDEPTH-1:0]] <= push_word;
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign head_word  = fifo_q[rptr_q[LGDEPTH-1:0]];

  assign S_AXI_RVALID = S_AXI_ARESETN & ~fifo_empty;
  assign S_AXI_RDATA  = S_AXI_RVALID ? head_word[DW+1:2] : '0;
  assign S_AXI_RRESP  = S_AXI_RVALID ? head_word[1:0] : 2'b00;

endmodule

// File: tb/tb_axil_mem_read.sv
// Bench for axil_mem_read: two instances (RD_LATENCY=1/LGDEPTH=2 and
// RD_LATENCY=3/LGDEPTH=3) share one AR/R stimulus stream. Each has its own
// memory model and a queue-based reference of accepted reads.
module tb_axil_mem_read;

  logic       clk;
  logic       rst_n;
  logic       arvalid;
  logic [6:0] araddr;
  logic [2:0] arprot;
  logic       rready;
  int         cyc;
  int         checks;
  int         failures;
  logic [31:0] mem [32];

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          t;
  } exp_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int inst, input string tag,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL inst%0d %s: observed=%0h expected=%0h", inst, tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int L     = (g == 0) ? 1 : 3;
    localparam int LGD   = (g == 0) ? 2 : 3;
    localparam int DEPTH = 1 << LGD;

    logic        arready, rvalid, rd_en;
    logic [31:0] rdata, rd_data;
    logic [1:0]  rresp;
    logic [4:0]  rd_addr;

    axil_mem_read #(
      .C_AXI_DATA_WIDTH(32),
      .C_AXI_ADDR_WIDTH(7),
      .LGDEPTH(LGD),
      .RD_LATENCY(L),
      .MEM_WORDS(16)
    ) u_dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_ARADDR(araddr),
      .S_AXI_ARPROT(arprot),
      .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready),
      .S_AXI_RDATA(rdata),
      .S_AXI_RRESP(rresp),
      .o_rd_en(rd_en),
      .o_rd_addr(rd_addr),
      .i_rd_data(rd_data)
    );

    // Memory: data is only meaningful L cycles after a real read strobe.
    logic [L-1:0] en_pipe;
    logic [4:0]   a_pipe [L];
    always @(posedge clk) begin
      en_pipe[0] <= rd_en;
      a_pipe[0]  <= rd_addr;
      for (int k = 1; k < L; k++) begin
        en_pipe[k] <= en_pipe[k-1];
        a_pipe[k]  <= a_pipe[k-1];
      end
    end
    assign rd_data = en_pipe[L-1] ? mem[a_pipe[L-1]] : 32'hBAD0_BAD0;

    // Reference: every accepted read becomes one expected response, due
    // L+1 cycles after its acceptance cycle, returned in acceptance order.
    exp_t       q [$];
    exp_t       e;
    int         pend;
    int         n_ar;
    int         n_r;
    logic [4:0] idx;
    logic       hs;
    logic       exp_rv;

    initial begin
      pend = 0;
      n_ar = 0;
      n_r  = 0;
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        chk(g, "reset arready", arready, 0);
        chk(g, "reset rvalid", rvalid, 0);
        chk(g, "reset rdata", rdata, 0);
        chk(g, "reset rresp", rresp, 0);
        chk(g, "reset rd_en", rd_en, 0);
        q.delete();
        pend = 0;
      end else begin
        idx = araddr[6:2];
        hs  = arvalid & arready;
        chk(g, "arready", arready, (q.size() < DEPTH));
        chk(g, "outstanding", u_dut.outst_q, q.size());
        chk(g, "rd_en", rd_en, hs && (idx < 16));
        if (hs && idx < 16) chk(g, "rd_addr", rd_addr, idx);
        exp_rv = 1'b0;
        if (q.size() != 0) exp_rv = (q[0].t + L + 1 <= cyc);
        chk(g, "rvalid", rvalid, exp_rv);
        if (rvalid && q.size() != 0) begin
          chk(g, "rdata", rdata, q[0].data);
          chk(g, "rresp", rresp, q[0].resp);
        end else if (!rvalid) begin
          chk(g, "idle rdata", rdata, 0);
          chk(g, "idle rresp", rresp, 0);
        end
        if (rvalid && rready) begin
          n_r++;
          if (q.size() != 0) void'(q.pop_front());
        end
        if (hs) begin
          n_ar++;
          e.data = (idx < 16) ? mem[idx] : 32'h0;
          e.resp = (idx < 16) ? 2'b00 : 2'b11;
          e.t    = cyc;
          q.push_back(e);
        end
        pend = q.size();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc;
  int r0, r1, a0, a1;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    arvalid  = 1'b0;
    araddr   = '0;
    arprot   = 3'b000;
    rready   = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    repeat (3) step();
    chk(0, "in-reset arready", gen_dut[0].arready, 0);
    rst_n = 1'b1;
    #1;
    chk(0, "arready after release", gen_dut[0].arready, 1);
    step();

    // Single read at byte address 0x08 -> word 2.
    rready  = 1'b1;
    arvalid = 1'b1;
    araddr  = 7'h08;
    arprot  = 3'b101;
    @(negedge clk);
    chk(0, "single rd_en", gen_dut[0].rd_en, 1);
    chk(0, "single rd_addr", gen_dut[0].rd_addr, 2);
    step();
    arvalid = 1'b0;
    chk(0, "single rvalid early", gen_dut[0].rvalid, 0);
    step();
    chk(0, "single rvalid", gen_dut[0].rvalid, 1);
    chk(0, "single rdata", gen_dut[0].rdata, mem[2]);
    chk(0, "single rresp", gen_dut[0].rresp, 0);
    step();

    // Decode error at 0x40 (word 16).
    arvalid = 1'b1;
    araddr  = 7'h40;
    @(negedge clk);
    chk(0, "decerr rd_en", gen_dut[0].rd_en, 0);
    step();
    arvalid = 1'b0;
    step();
    chk(0, "decerr rvalid", gen_dut[0].rvalid, 1);
    chk(0, "decerr rdata", gen_dut[0].rdata, 0);
    chk(0, "decerr rresp", gen_dut[0].rresp, 3);
    repeat (6) step();

    // Backpressure: 6 back-to-back ARs with RREADY low.
    rready = 1'b0;
    acc    = 0;
    r0     = gen_dut[0].n_r;
    for (int i = 0; i < 6; i++) begin
      arvalid = 1'b1;
      araddr  = 7'($urandom);
      @(negedge clk);
      if (gen_dut[0].arready) acc++;
      step();
    end
    chk(0, "bp accepted", acc, 4);
    chk(0, "bp arready", gen_dut[0].arready, 0);
    repeat (2) step();
    chk(0, "full outstanding held", gen_dut[0].u_dut.outst_q, 4);
    chk(0, "full arready held", gen_dut[0].arready, 0);
    arvalid = 1'b0;
    rready  = 1'b1;
    chk(0, "arready at first R", gen_dut[0].arready, 0);
    step();
    chk(0, "arready after first R", gen_dut[0].arready, 1);
    repeat (10) step();
    chk(0, "bp responses", gen_dut[0].n_r - r0, 4);

    // Streaming: 32 reads back to back with RREADY held high.
    a0 = gen_dut[0].n_ar;
    a1 = gen_dut[1].n_ar;
    r0 = gen_dut[0].n_r;
    r1 = gen_dut[1].n_r;
    for (int i = 0; i < 32; i++) begin
      arvalid = 1'b1;
      araddr  = 7'((i % 16) * 4);
      step();
    end
    arvalid = 1'b0;
    chk(0, "stream accepted", gen_dut[0].n_ar - a0, 32);
    chk(1, "stream accepted", gen_dut[1].n_ar - a1, 32);
    repeat (6) step();
    chk(0, "stream responses", gen_dut[0].n_r - r0, 32);
    chk(1, "stream responses", gen_dut[1].n_r - r1, 32);

    // Reset pulsed in the middle of three outstanding reads.
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arvalid = 1'b1;
      araddr  = 7'(i * 4);
      step();
    end
    arvalid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk(0, "async reset rvalid", gen_dut[0].rvalid, 0);
    chk(1, "async reset rvalid", gen_dut[1].rvalid, 0);
    step();
    rst_n  = 1'b1;
    rready = 1'b1;
    #1;
    chk(0, "post-reset outstanding", gen_dut[0].u_dut.outst_q, 0);
    chk(0, "post-reset arready", gen_dut[0].arready, 1);
    r0 = gen_dut[0].n_r;
    r1 = gen_dut[1].n_r;
    repeat (10) step();
    chk(0, "no stale responses", gen_dut[0].n_r - r0, 0);
    chk(1, "no stale responses", gen_dut[1].n_r - r1, 0);

    // Random traffic, mixed OKAY/DECERR, random backpressure.
    for (int i = 0; i < 400; i++) begin
      arvalid = ($urandom_range(9) < 7);
      araddr  = 7'($urandom);
      arprot  = 3'($urandom);
      rready  = ($urandom_range(3) != 0);
      step();
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    repeat (20) step();
    chk(0, "drained", gen_dut[0].pend, 0);
    chk(1, "drained", gen_dut[1].pend, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
